conv2_relu_maxpool: RTL and testbench
=====================================

CONV2_RELU_MAXPOOL -- requirements
Module: conv2_relu_maxpool

Interface
REQ-001 Parameter: DATA_W, 14, signed width of input pixel and pooled output.
REQ-002 Parameter: IMG_W, 8, feature-map columns (even, >= 2).
REQ-003 Parameter: IMG_H, 8, feature-map rows (even, >= 2).
REQ-004 Parameter: BIAS, 0, signed DATA_W-bit bias constant added to every pixel.
REQ-005 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-006 Port: rst  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
REQ-007 Port: valid_in  input  1  conv_in holds a valid conv2 pixel this cycle.
REQ-008 Port: conv_in  input  DATA_W  signed conv2 accumulator output (already scaled), raster order.
REQ-009 Port: data_out  output  DATA_W  signed pooled result (always >= 0), registered.
REQ-010 Port: valid_out  output  1  one-cycle pulse; data_out valid.
REQ-011 Port: frame_done  output  1  one-cycle pulse coincident with the last valid_out of a frame.

Function
REQ-012 The block SHALL accept one pixel per clk edge with valid_in=1; cycles with valid_in=0 SHALL leave all state unchanged (gaps of any length allowed).
REQ-013 Each accepted pixel SHALL be biased: s = conv_in + BIAS computed at DATA_W+1 bits, saturated to [-(2^(DATA_W-1)), 2^(DATA_W-1)-1].
REQ-014 ReLU SHALL follow: r = (s < 0) ? 0 : s.
REQ-015 Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) SHALL track position; col increments per accepted pixel, wraps to 0 after IMG_W-1 and increments row; row wraps to 0 after IMG_H-1.
REQ-016 Even col: r SHALL be held in pair register P.
REQ-017 Odd col, even row: max(P, r) SHALL be written to row buffer entry B[col>>1] (IMG_W/2 entries).
REQ-018 Odd col, odd row: the block SHALL register data_out = max(P, r, B[col>>1]) and assert valid_out for exactly one cycle on the following cycle (latency 1 clk from the accepting edge).
REQ-019 All max comparisons SHALL be signed; ties select either operand (results identical).
REQ-020 Outputs per frame SHALL be exactly (IMG_W/2)*(IMG_H/2) = 16 at defaults, in raster order of the pooled map.
REQ-021 frame_done SHALL pulse with valid_out for the pixel at row=IMG_H-1, col=IMG_W-1; counters SHALL be 0 on the next cycle, ready for the next frame with no dead cycle.
REQ-022 data_out SHALL hold its last value while valid_out=0.
REQ-023 Back-to-back frames with continuous valid_in SHALL be supported; a new frame's first pixel may be accepted the cycle after frame_done's accepting edge.

Reset
REQ-024 When rst=0: col, row, P, all B entries, data_out SHALL be 0; valid_out, frame_done SHALL be 0.
REQ-025 Reset mid-frame SHALL discard the partial frame; the first pixel accepted after release SHALL be treated as row 0, col 0.
REQ-026 valid_in sampled during reset SHALL be ignored.

Verification
REQ-027 Reset check: hold rst=0 for 3 cycles with valid_in=1 -> valid_out=0, frame_done=0, data_out=0 throughout.
REQ-028 Ramp frame, BIAS=0: conv_in = row*8+col for 64 continuous pixels -> 16 pulses, data_out = 9,11,13,15,25,...,63; frame_done with value 63.
REQ-029 ReLU/bias: BIAS=-10, all pixels 5 except pixel (1,1)=100 -> first output 90, remaining 15 outputs 0.
REQ-030 Saturation: BIAS=100, conv_in=8150 everywhere -> every output 8191; conv_in=-8192, BIAS=-100 -> every output 0 (no wrap to positive).
REQ-031 Gapped input: ramp frame with valid_in toggling 1,0 (one-cycle gaps, as produced upstream) -> same 16 values as REQ-028, each valid_out exactly one cycle after its accepting edge.
REQ-032 Mid-frame reset: assert rst=0 after 20 pixels, release, send full ramp frame -> exactly 16 outputs matching REQ-028, no stale values from the aborted frame.

Source files
------------

// File: rtl/conv2_relu_maxpool.sv
// Bias + saturate + ReLU on a raster stream of conv2 pixels, followed by 2x2
// max pooling using one pair register and a half-width row buffer.
module conv2_relu_maxpool #(
  parameter int                        DATA_W = 14,
  parameter int                        IMG_W  = 8,
  parameter int                        IMG_H  = 8,
  parameter logic signed [DATA_W-1:0]  BIAS   = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic signed [DATA_W-1:0] conv_in,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     valid_out,
  output logic                     frame_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int HALF  = IMG_W / 2;
  localparam int IDX_W = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [COL_W-1:0]        COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]        ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic [COL_W-1:0]        col_q;
  logic [ROW_W-1:0]        row_q;
  logic signed [DATA_W-1:0] pair_q;
  logic signed [DATA_W-1:0] row_buf [HALF];

  logic signed [DATA_W:0]   sum;
  logic signed [DATA_W-1:0] sat;
  logic signed [DATA_W-1:0] relu;
  logic [IDX_W-1:0]         idx;
  logic signed [DATA_W-1:0] row_entry;
  logic signed [DATA_W-1:0] pair_max;
  logic signed [DATA_W-1:0] pool_max;
  logic                     col_last;
  logic                     row_last;

  // One extra bit of headroom; overflow shows as the top two bits disagreeing.
  assign sum = {conv_in[DATA_W-1], conv_in} + {BIAS[DATA_W-1], BIAS};

  always_comb begin
    sat = sum[DATA_W-1:0];
    if (sum[DATA_W] != sum[DATA_W-1]) begin
      sat = sum[DATA_W] ? SAT_MIN : SAT_MAX;
    end
    relu = sat[DATA_W-1] ? '0 : sat;
  end

  assign idx       = IDX_W'(col_q >> 1);
  assign row_entry = row_buf[idx];
  assign pair_max  = (pair_q > relu) ? pair_q : relu;
  assign pool_max  = (pair_max > row_entry) ? pair_max : row_entry;
  assign col_last  = (col_q == COL_LAST);
  assign row_last  = (row_q == ROW_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q      <= '0;
      row_q      <= '0;
      pair_q     <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < HALF; i++) begin
        row_buf[i] <= '0;
      end
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        // Even column: stash; odd column of even row: fold pair into buffer;
        // odd column of odd row: fold pair with buffered upper row and emit.
        if (!col_q[0]) begin
          pair_q <= relu;
        end else if (!row_q[0]) begin
          row_buf[idx] <= pair_max;
        end else begin
          data_out   <= pool_max;
          valid_out  <= 1'b1;
          frame_done <= row_last & col_last;
        end

        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_conv2_relu_maxpool.sv
// Directed bench for conv2_relu_maxpool: four instances with different BIAS
// share one stimulus stream; a selected instance is scored against a 2x2 pool model.
module tb_conv2_relu_maxpool;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic               valid_in = 1'b0;
  logic signed [13:0] conv_in  = '0;

  logic [13:0] dout [4];
  logic        vout [4];
  logic        fd   [4];

  conv2_relu_maxpool #(.DATA_W(14), .IMG_W(8), .IMG_H(8), .BIAS(14'sd0)) u_b0 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .conv_in(conv_in),
    .data_out(dout[0]), .valid_out(vout[0]), .frame_done(fd[0]));
  conv2_relu_maxpool #(.DATA_W(14), .IMG_W(8), .IMG_H(8), .BIAS(-14'sd10)) u_bm10 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .conv_in(conv_in),
    .data_out(dout[1]), .valid_out(vout[1]), .frame_done(fd[1]));
  conv2_relu_maxpool #(.DATA_W(14), .IMG_W(8), .IMG_H(8), .BIAS(14'sd100)) u_b100 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .conv_in(conv_in),
    .data_out(dout[2]), .valid_out(vout[2]), .frame_done(fd[2]));
  conv2_relu_maxpool #(.DATA_W(14), .IMG_W(8), .IMG_H(8), .BIAS(-14'sd100)) u_bm100 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .conv_in(conv_in),
    .data_out(dout[3]), .valid_out(vout[3]), .frame_done(fd[3]));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int sel    = 0;
  int exp_hold [4];

  logic [13:0] exp_q     [$];
  int          exp_cyc_q [$];
  logic        exp_fd_q  [$];
  logic [13:0] got_q     [$];

  int pix [8][8];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: every pulse must match the head of the queue; between pulses
  // the output must hold the last expected value and frame_done stay low.
  always @(negedge clk) begin
    if (rst) begin
      if (vout[sel]) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid_out", 1, 0);
        end else begin
          logic [13:0] e;
          int          ec;
          logic        ef;
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          ef = exp_fd_q.pop_front();
          check("data_out", int'(dout[sel]), int'(e));
          check("frame_done", int'(fd[sel]), int'(ef));
          check("latency_cycle", cyc, ec);
          exp_hold[sel] = int'(e);
          got_q.push_back(dout[sel]);
        end
      end else begin
        check("hold_data_out", int'(dout[sel]), exp_hold[sel]);
        check("frame_done_idle", int'(fd[sel]), 0);
      end
    end
  end

  // ---------------- model ----------------
  function automatic int act(input int v, input int b);
    int s;
    s = v + b;
    if (s > 8191)  s = 8191;
    if (s < -8192) s = -8192;
    return (s < 0) ? 0 : s;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic build(input int kind, input int fill, input int spike);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        pix[r][c] = (kind == 0) ? r * 8 + c : fill;
    if (kind == 1) pix[1][1] = spike;
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset(input int ncyc);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) exp_hold[i] = 0;
    repeat (ncyc) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic run_frame(input int bias, input bit gapped, input int npix);
    for (int k = 0; k < npix; k++) begin
      int r, c, e;
      r = k / 8;
      c = k % 8;
      valid_in = 1'b1;
      conv_in  = 14'(pix[r][c]);
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        e = max2(max2(act(pix[r-1][c-1], bias), act(pix[r-1][c], bias)),
                 max2(act(pix[r][c-1], bias), act(pix[r][c], bias)));
        exp_q.push_back(14'(e));
        exp_cyc_q.push_back(cyc + 1);
        exp_fd_q.push_back((r == 7) && (c == 7));
      end
      @(posedge clk); #1;
      valid_in = 1'b0;
      if (gapped) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_drain_pending"}, exp_q.size(), 0);
    exp_q.delete();
    exp_cyc_q.delete();
    exp_fd_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string name;
    int    inst;
    int    bias;
    int    kind;     // 0 ramp, 1 fill with spike at (1,1), 2 constant fill
    int    fill;
    int    spike;
    bit    gapped;
    int    nframes;
    int    exp_first;
    int    exp_last;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{"ramp_b2b",      0,    0, 0,     0,   0, 1'b0, 2,    9,   63};
    vecs[1] = '{"relu_bias",     1,  -10, 1,     5, 100, 1'b0, 1,   90,    0};
    vecs[2] = '{"sat_pos",       2,  100, 2,  8150,   0, 1'b0, 1, 8191, 8191};
    vecs[3] = '{"sat_neg",       3, -100, 2, -8192,   0, 1'b0, 1,    0,    0};
    vecs[4] = '{"ramp_gapped",   0,    0, 0,     0,   0, 1'b1, 1,    9,   63};

    // Reset with valid_in asserted must produce nothing.
    rst      = 1'b0;
    valid_in = 1'b1;
    conv_in  = 14'sd100;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        check("rst_valid_out", int'(vout[i]), 0);
        check("rst_frame_done", int'(fd[i]), 0);
        check("rst_data_out", int'(dout[i]), 0);
      end
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int v = 0; v < 5; v++) begin
      do_reset(2);
      sel = vecs[v].inst;
      got_q.delete();
      build(vecs[v].kind, vecs[v].fill, vecs[v].spike);
      for (int f = 0; f < vecs[v].nframes; f++)
        run_frame(vecs[v].bias, vecs[v].gapped, 64);
      drain(vecs[v].name);
      check({vecs[v].name, "_count"}, got_q.size(), 16 * vecs[v].nframes);
      if (got_q.size() > 0) begin
        check({vecs[v].name, "_first"}, int'(got_q[0]), vecs[v].exp_first);
        check({vecs[v].name, "_last"}, int'(got_q[got_q.size()-1]), vecs[v].exp_last);
      end
    end

    // Ramp spot values from the hand-derived sequence 9,11,13,15,25,...,63.
    do_reset(2);
    sel = 0;
    got_q.delete();
    build(0, 0, 0);
    run_frame(0, 1'b0, 64);
    drain("ramp_spot");
    check("ramp_spot_count", got_q.size(), 16);
    if (got_q.size() == 16) begin
      check("ramp_spot_1", int'(got_q[1]), 11);
      check("ramp_spot_4", int'(got_q[4]), 25);
      check("ramp_spot_10", int'(got_q[10]), 45);
    end

    // Abort a frame after 20 pixels, then a clean frame must start at (0,0).
    do_reset(2);
    sel = 0;
    build(0, 0, 0);
    run_frame(0, 1'b0, 20);
    drain("abort_part");
    do_reset(2);
    got_q.delete();
    run_frame(0, 1'b0, 64);
    drain("after_abort");
    check("after_abort_count", got_q.size(), 16);
    if (got_q.size() > 0) begin
      check("after_abort_first", int'(got_q[0]), 9);
      check("after_abort_last", int'(got_q[got_q.size()-1]), 63);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
